// File: rtl/burst_sched_pkg.sv
// ============================================================================
// Module  : burst_sched_pkg
// Brief   : Shared types and helpers for the burst round-robin scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package burst_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int unsigned N_DEF = 4;
  localparam int unsigned IDX_W = $clog2(N_DEF);

  // Caller guarantees at most one bit set; OR-accumulation keeps it mux-free.
  function automatic logic [31:0] onehot_to_idx(input logic [31:0] oh);
    logic [31:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx |= 32'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/burst_rr_scheduler_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational masked/unmasked dual-priority pick, lowest index wins.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic [N-1:0] win,
  output logic         valid
);

  logic [N-1:0] w_masked;
  logic [N-1:0] w_mwin;
  logic [N-1:0] w_uwin;

  // x & -x isolates the lowest set bit
  assign w_masked = req & mask;
  assign w_mwin   = w_masked & (~w_masked + N'(1));
  assign w_uwin   = req & (~req + N'(1));
  assign win      = (|w_masked) ? w_mwin : w_uwin;
  assign valid    = |req;

endmodule

`default_nettype wire

// File: rtl/burst_rr_scheduler.sv
// ============================================================================
// Module  : burst_rr_scheduler
// Brief   : Round-robin burst arbiter with beat counting and stall watchdog.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_rr_scheduler #(
  parameter int N       = 4,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N*LEN_W-1:0]   req_len,
  input  logic                 beat_ack,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 busy,
  output logic [N-1:0]         done,
  output logic                 timeout_err
);
  import burst_sched_pkg::*;

  localparam int IW = $clog2(N);
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] WD_SAT  = TO_W'(TIMEOUT);

  state_t           r_state, w_state_nxt;
  logic [N-1:0]     r_gnt, w_gnt_nxt;
  logic [N-1:0]     r_mask, w_mask_nxt;
  logic [N-1:0]     r_done, w_done_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt, w_win_len;
  logic [TO_W-1:0]  r_wd, w_wd_nxt;
  logic             r_to, w_to_nxt;
  logic [N-1:0]     w_win;
  logic             w_valid;
  logic             w_last_beat;
  logic             w_wd_fire;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .mask  (r_mask),
    .win   (w_win),
    .valid (w_valid)
  );

  always_comb begin
    w_win_len = '0;
    for (int i = 0; i < N; i++) begin
      if (w_win[i]) w_win_len |= req_len[i*LEN_W +: LEN_W];
    end
  end

  // An ack in the firing cycle takes precedence over the watchdog
  assign w_last_beat = beat_ack && (r_cnt == '0);
  assign w_wd_fire   = !beat_ack && (r_wd == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE, RELEASE: w_state_nxt = w_valid ? OWN : IDLE;
      OWN:           w_state_nxt = (w_last_beat || w_wd_fire) ? RELEASE : OWN;
      default:       w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nxt  = r_gnt;
    w_mask_nxt = r_mask;
    w_idx_nxt  = r_idx;
    w_cnt_nxt  = r_cnt;
    w_wd_nxt   = r_wd;
    w_done_nxt = '0;
    w_to_nxt   = 1'b0;
    case (r_state)
      OWN: begin
        if (beat_ack) begin
          w_wd_nxt = '0;
          if (r_cnt == '0) begin
            w_gnt_nxt  = '0;
            w_done_nxt = r_gnt;
          end else begin
            w_cnt_nxt = r_cnt - LEN_W'(1);
          end
        end else if (w_wd_fire) begin
          w_gnt_nxt = '0;
          w_to_nxt  = 1'b1;
          w_wd_nxt  = WD_SAT;
        end else begin
          w_wd_nxt = r_wd + TO_W'(1);
        end
      end
      default: begin
        w_gnt_nxt = w_win;
        if (w_valid) begin
          w_cnt_nxt  = w_win_len;
          w_wd_nxt   = '0;
          w_idx_nxt  = IW'(onehot_to_idx(32'(w_win)));
          // next search begins strictly above the new owner
          w_mask_nxt = ~(w_win | (w_win - N'(1)));
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt  <= '0;
      r_mask <= '1;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_wd   <= '0;
      r_done <= '0;
      r_to   <= 1'b0;
    end else begin
      r_gnt  <= w_gnt_nxt;
      r_mask <= w_mask_nxt;
      r_idx  <= w_idx_nxt;
      r_cnt  <= w_cnt_nxt;
      r_wd   <= w_wd_nxt;
      r_done <= w_done_nxt;
      r_to   <= w_to_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign gnt_idx     = r_idx;
  assign busy        = |r_gnt;
  assign done        = r_done;
  assign timeout_err = r_to;

endmodule

`default_nettype wire
